keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix keypad scanner for the 4x3 board keypad, running on the 1 kHz system clock. It drives the column lines, samples the row lines, resolves and debounces a single key, and reports it upstream. It produces the `key_star` level consumed by the top-level synchronizer/edge detector, plus a general key code and press strobe for future game input.

## Interface
- `SCAN_DIV`, 4: clock cycles per column slot; must be ≥ 3.
- `DEBOUNCE`, 5: consecutive identical frames required to accept a change; range 1..15.
- `REPEAT_FRAMES`, 40: auto-repeat period in frames; used only with `KEYPAD_REPEAT_EN`.
- `clk_1khz`  in  1  system clock, 1 kHz.
- `rst`  in  1  asynchronous, active-high reset.
- `key_row`  in  4  row lines, active-high, asynchronous to the clock.
- `key_col`  out  3  one-hot column drive, active-high.
- `key_code`  out  4  debounced key code; 4'hF means no key.
- `key_valid`  out  1  one-cycle press strobe, qualified by `key_code`.
- `key_held`  out  1  high while the debounced code is not 4'hF.
- `key_star`  out  1  high while the debounced code is 4'hA (`*`).

## Operation
- **Column scan**
  - Slot counter runs 0..SCAN_DIV-1. Column index runs 0..2 and advances on slot wrap.
  - `key_col` = 1 << column index. One frame = 3*SCAN_DIV cycles.
- **Row sampling**
  - `key_row` passes through a 2-flop synchronizer.
  - The synchronized value is captured on the last cycle of each slot.
- **Key map** (row r, column c)
  - Rows 0..2: code = 3r + c + 1, giving digits 1..9.
  - Row 3: c0 = 4'hA (`*`), c1 = 4'h0, c2 = 4'hB (`#`).
- **Frame result**
  - Exactly one asserted row/column intersection in the frame: its code.
  - Zero intersections, or two or more (ghosting/multi-press): 4'hF.
- **Debounce FSM** (states IDLE, CHECK)
  - The candidate equals the previous frame result: stable count increments, saturating at DEBOUNCE.
  - Otherwise the stable count reloads to 1.
  - The stable count reaching DEBOUNCE with candidate ≠ `key_code`: `key_code` takes the candidate.
- **Press strobe**
  - `key_valid` pulses when `key_code` changes to a value ≠ 4'hF. This includes direct key-to-key transitions.
  - A change to 4'hF (release) produces no pulse.
- **Level outputs**: `key_held` and `key_star` are decoded from the registered `key_code`, so they are glitch-free.
- **Reset values**
  - Outputs: `key_col`=3'b001, `key_code`=4'hF, `key_valid`=0, `key_held`=0, `key_star`=0.
  - Internal: all counters zero, synchronizer zero.
  - Reset asserted mid-frame aborts the frame. The scan restarts at column 0 on the first clock after release.

## Timing
- Column lines change on the clock edge after slot count SCAN_DIV-1; there is no dead cycle between columns.
- The settle time before sampling is SCAN_DIV-1 cycles, covering the 2-cycle synchronizer latency.
- The frame result is evaluated on the last cycle of column 2.
- `key_code`, `key_valid`, `key_held` and `key_star` update together, 1 cycle after that frame-end cycle.
- Press latency, from a stable press to `key_valid`: DEBOUNCE frames + ≤1 frame alignment + 1 cycle.
  - Default: ≤ 6×12+1 = 73 ms.
- Release latency, to `key_held`=0: the same bound.
- `key_valid` is never high on two consecutive cycles.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - While `key_code` ≠ 4'hF and unchanged, a frame counter runs from acceptance.
  - `key_valid` re-pulses every REPEAT_FRAMES frames, at the same frame-end+1 phase.
  - The counter clears on any `key_code` change.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one `key_valid` per accepted code.
  - No repeat counter is synthesized.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3, so one frame = 12 cycles.
- Reset then idle rows 0 → `key_col` 001 (cycles 0-3), 010 (4-7), 100 (8-11), 001 at cycle 12; all other outputs at reset values; no `key_valid` over 20 frames.
- Row 1 asserted whenever column 1 is driven (key `5`), held 10 frames → single `key_valid` with `key_code`=4'h5 within 4 frames + 1 cycle; `key_held`=1.
  - Then release → `key_held`=0 and `key_code`=4'hF within 4 frames, no pulse.
- `5` bounces (present/absent alternating for 4 frames) then stable → exactly one `key_valid`, `key_code`=4'h5.
- Row 3 asserted when column 0 is driven (`*`) → `key_star`=1 and `key_code`=4'hA.
  - With the top-level sync/edge detector attached, exactly one rising edge of `key_star` is seen.
- Keys `1` and `2` pressed together for 10 frames → no `key_valid`, `key_code` stays 4'hF.
  - Assert `rst` mid-frame during a press → outputs return to reset values immediately, and the scan resumes at column 0.
- `#` held 100 frames → pulse count depends on the macro:
  - With `KEYPAD_REPEAT_EN` and REPEAT_FRAMES=40: 3 pulses, at acceptance, +40 frames and +80 frames, each with `key_code`=4'hB.
  - Without the macro: 1 pulse.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: column drive, synchronised row sampling, single-key debounce.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_FRAMES frames while a key is held.
module keypad_scan #(
    parameter int unsigned SCAN_DIV      = 4,
    parameter int unsigned DEBOUNCE      = 5,
    parameter int unsigned REPEAT_FRAMES = 40
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_star
);

    localparam int unsigned SlotW = $clog2(SCAN_DIV);

    typedef enum logic {StIdle, StCheck} state_e;

    if (SCAN_DIV < 3 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_cfg_err
        $error("keypad_scan: parameter out of range");
    end

    function automatic logic [3:0] key_map(input int unsigned r, input int unsigned c);
        if (r < 3) return 4'(3 * r + c + 1);
        case (c)
            0:       return 4'hA;
            1:       return 4'h0;
            default: return 4'hB;
        endcase
    endfunction

    logic [SlotW-1:0] slot_q, slot_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       row_s1_q, row_s2_q, cap0_q, cap1_q;
    logic [3:0]       prev_q, prev_d, stable_q, stable_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d, held_q, held_d, star_q, star_d;
    state_e           state_q, state_d;
    logic             slot_last, frame_end, accept, rpt_fire;
    logic [3:0]       frame_rows [3];
    logic [3:0]       hits, found, cand;

    assign slot_last = (slot_q == SlotW'(SCAN_DIV - 1));
    assign frame_end = slot_last && (col_q == 2'd2);

    always_comb begin
        slot_d = slot_last ? '0 : slot_q + SlotW'(1);
        col_d  = col_q;
        if (slot_last) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    end

    // Column 2 is evaluated from the live synchronizer output on the frame-end cycle.
    assign frame_rows[0] = cap0_q;
    assign frame_rows[1] = cap1_q;
    assign frame_rows[2] = row_s2_q;

    always_comb begin
        hits  = '0;
        found = 4'hF;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (frame_rows[c][r]) begin
                    hits  = hits + 4'd1;
                    found = key_map(r, c);
                end
            end
        end
        cand = (hits == 4'd1) ? found : 4'hF;
    end

    // State register.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            slot_q   <= '0;
            col_q    <= '0;
            row_s1_q <= '0;
            row_s2_q <= '0;
            cap0_q   <= '0;
            cap1_q   <= '0;
            prev_q   <= 4'hF;
            stable_q <= '0;
            state_q  <= StIdle;
            code_q   <= 4'hF;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
            star_q   <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            col_q    <= col_d;
            row_s1_q <= key_row;
            row_s2_q <= row_s1_q;
            if (slot_last && col_q == 2'd0) cap0_q <= row_s2_q;
            if (slot_last && col_q == 2'd1) cap1_q <= row_s2_q;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
            star_q   <= star_d;
        end
    end

    // Next-state logic for the debounce FSM.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (frame_end) begin
            prev_d = cand;
            if (cand != prev_q)                  stable_d = 4'd1;
            else if (stable_q != 4'(DEBOUNCE))   stable_d = stable_q + 4'd1;
            accept = (stable_d == 4'(DEBOUNCE)) && (cand != code_q);
            unique case (state_q)
                StIdle:  if (cand != code_q && !accept) state_d = StCheck;
                StCheck: if (accept || cand == code_q)  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_FRAMES + 1);

    logic [RptW-1:0] rpt_q, rpt_d;

    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (frame_end) begin
            if (accept || code_q == 4'hF) begin
                rpt_d = '0;
            end else if (rpt_q == RptW'(REPEAT_FRAMES - 1)) begin
                rpt_d    = '0;
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + RptW'(1);
            end
        end
    end

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) rpt_q <= '0;
        else     rpt_q <= rpt_d;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Output logic: all key outputs are registered so they change together.
    always_comb begin
        code_d  = accept ? cand : code_q;
        valid_d = (accept && cand != 4'hF) || rpt_fire;
        held_d  = (code_d != 4'hF);
        star_d  = (code_d == 4'hA);
    end

    assign key_col   = 3'(3'b001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign key_star  = star_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a key-matrix model drives the rows and a
// scoreboard queue holds the key codes expected on each key_valid strobe.
`timescale 1us/1ns
module tb_keypad_scan;

    localparam int unsigned ScanDiv      = 4;
    localparam int unsigned Debounce     = 3;
    localparam int unsigned RepeatFrames = 40;
    localparam int          Frame        = 3 * ScanDiv;
    localparam int          LatBudget    = (Debounce + 1) * Frame + 1;

    logic       clk_1khz = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_code;
    logic       key_valid, key_held, key_star;

    logic [11:0] pressed = '0;  // bit r*3+c

    int         n_checks = 0, n_errors = 0;
    logic [3:0] exp_q [$];
    int         pulses = 0, extra = 0, doubles = 0, star_rises = 0;
    logic       valid_prev = 1'b0, star_prev = 1'b0;

    keypad_scan #(
        .SCAN_DIV      (ScanDiv),
        .DEBOUNCE      (Debounce),
        .REPEAT_FRAMES (RepeatFrames)
    ) u_dut (
        .clk_1khz  (clk_1khz),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_star  (key_star)
    );

    always #500 clk_1khz = ~clk_1khz;

    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r * 3 + c] && key_col[c]) key_row[r] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_1khz) begin
        if (key_valid) begin
            pulses++;
            if (valid_prev) doubles++;
            if (exp_q.size() > 0) check("valid_code", 32'(key_code), 32'(exp_q.pop_front()));
            else extra++;
        end
        if (key_star && !star_prev) star_rises++;
        valid_prev = key_valid;
        star_prev  = key_star;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk_1khz);
            lat++;
        end while (!key_valid && lat < budget);
    endtask

    task automatic wait_held(input logic lvl, input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk_1khz);
            lat++;
        end while (key_held !== lvl && lat < budget);
    endtask

    initial begin
        #(20000 * 1000);
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat, rises0, exp_n;
        cycles(3);
        rst = 1'b0;
        check("rst_col", 32'(key_col), 32'h1);
        check("rst_code", 32'(key_code), 32'hF);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        check("rst_star", 32'(key_star), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_1khz);
            check("col_seq", 32'(key_col), 32'(3'b001 << ((k / 4) % 3)));
        end
        base = pulses;
        cycles(20 * Frame);
        check("idle_pulses", 32'(pulses - base), 32'h0);
        check("idle_code", 32'(key_code), 32'hF);

        // Single key '5', then release.
        cycles(5);
        base = pulses;
        exp_q.push_back(4'h5);
        pressed[1 * 3 + 1] = 1'b1;
        wait_valid(LatBudget, lat);
        check("press_valid", 32'(key_valid), 32'h1);
        check("press_held", 32'(key_held), 32'h1);
        cycles(10 * Frame - lat);
        check("press_pulses", 32'(pulses - base), 32'h1);
        pressed = '0;
        wait_held(1'b0, LatBudget, lat);
        check("rel_held", 32'(key_held), 32'h0);
        check("rel_code", 32'(key_code), 32'hF);
        cycles(2 * Frame);
        check("rel_pulses", 32'(pulses - base), 32'h1);

        // Bouncing '5' settling to a stable press.
        base = pulses;
        exp_q.push_back(4'h5);
        for (int i = 0; i < 4; i++) begin
            pressed[1 * 3 + 1] = (i % 2 == 0);
            cycles(Frame);
        end
        pressed[1 * 3 + 1] = 1'b1;
        cycles(10 * Frame);
        check("bounce_pulses", 32'(pulses - base), 32'h1);
        check("bounce_code", 32'(key_code), 32'h5);
        pressed = '0;
        wait_held(1'b0, LatBudget, lat);
        check("bounce_rel", 32'(key_held), 32'h0);
        cycles(2 * Frame);

        // Star key.
        base   = pulses;
        rises0 = star_rises;
        exp_q.push_back(4'hA);
        pressed[3 * 3 + 0] = 1'b1;
        cycles(10 * Frame);
        check("star_level", 32'(key_star), 32'h1);
        check("star_code", 32'(key_code), 32'hA);
        pressed = '0;
        wait_held(1'b0, LatBudget, lat);
        cycles(Frame);
        check("star_off", 32'(key_star), 32'h0);
        check("star_rises", 32'(star_rises - rises0), 32'h1);
        check("star_pulses", 32'(pulses - base), 32'h1);

        // Keys '1' and '2' together: ghosting must be rejected.
        base = pulses;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        for (int f = 0; f < 10; f++) begin
            cycles(Frame);
            check("ghost_code", 32'(key_code), 32'hF);
        end
        check("ghost_pulses", 32'(pulses - base), 32'h0);
        pressed = '0;
        cycles(2 * Frame);

        // Reset mid-frame during a press.
        base = pulses;
        exp_q.push_back(4'h5);
        pressed[1 * 3 + 1] = 1'b1;
        wait_valid(LatBudget, lat);
        check("pre_rst_valid", 32'(key_valid), 32'h1);
        cycles(Frame + 5);
        rst = 1'b1;
        pressed = '0;
        #1;
        check("mid_rst_col", 32'(key_col), 32'h1);
        check("mid_rst_code", 32'(key_code), 32'hF);
        check("mid_rst_held", 32'(key_held), 32'h0);
        check("mid_rst_valid", 32'(key_valid), 32'h0);
        cycles(3);
        rst = 1'b0;
        cycles(3);
        check("post_rst_col0", 32'(key_col), 32'h1);
        cycles(1);
        check("post_rst_col1", 32'(key_col), 32'h2);
        cycles(6 * Frame);
        check("rst_pulses", 32'(pulses - base), 32'h1);

        // '#' held for 100 frames.
`ifdef KEYPAD_REPEAT_EN
        exp_n = 3;
`else
        exp_n = 1;
`endif
        base = pulses;
        for (int i = 0; i < exp_n; i++) exp_q.push_back(4'hB);
        pressed[3 * 3 + 2] = 1'b1;
        cycles(100 * Frame);
        check("hash_code", 32'(key_code), 32'hB);
        pressed = '0;
        wait_held(1'b0, LatBudget, lat);
        cycles(2 * Frame);
        check("hash_pulses", 32'(pulses - base), 32'(exp_n));

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        check("extra_valid", 32'(extra), 32'h0);
        check("valid_twice", 32'(doubles), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
